// File: rtl/seg_display_pkg.sv
// Shared types and seven-segment patterns for the display engine.
// Patterns are bit-ordered g..a and active-low.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam logic [6:0] SEG_DIGIT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_encode.sv
// Nibble to active-low seven-segment pattern; dash wins over blank.
module seg7_encode
  import seg_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  assign o_seg = i_dash  ? SEG_DASH  :
                 i_blank ? SEG_BLANK :
                           SEG_DIGIT[i_nibble];

endmodule

// File: rtl/seg_display_engine.sv
// Sequential binary-to-display engine: double-dabble decimal (one bit per
// cycle) or hex pass-through, with leading-zero blanking and overflow dashes.
module seg_display_engine
  import seg_display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;

  if (WIDTH < 1 || WIDTH > 32 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
    $error("seg_display_engine: WIDTH must be 1..32 and DIGITS 1..8");
  end

  state_t              r_state;
  logic [BW-1:0]       r_bcd;
  logic [WIDTH-1:0]    r_bin;
  logic [4:0]          r_cnt;
  logic                r_hex;
  logic                r_blank_lz;
  logic                r_ovf_dec;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [7*DIGITS-1:0] r_seg;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_digits;
  logic [63:0]         w_bin_ext;
  logic                w_hex_ovf;
  logic                w_ovf;
  logic [DIGITS-1:0]   w_blank;
  logic [7*DIGITS-1:0] w_seg;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Hex digits come straight from the captured value; anything above the
  // displayable nibbles is overflow.
  assign w_bin_ext = 64'(r_bin);
  assign w_hex_ovf = |(w_bin_ext >> BW);
  assign w_digits  = r_hex ? w_bin_ext[BW-1:0] : r_bcd;
  assign w_ovf     = r_hex ? w_hex_ovf : r_ovf_dec;

  always_comb begin
    logic v_seen;
    v_seen  = 1'b0;
    w_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (w_digits[4*k +: 4] != 4'd0) v_seen = 1'b1;
      w_blank[k] = r_blank_lz && !v_seen && (k != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .i_nibble (w_digits[4*g +: 4]),
      .i_blank  (w_blank[g]),
      .i_dash   (w_ovf),
      .o_seg    (w_seg[7*g +: 7])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_hex      <= 1'b0;
      r_blank_lz <= 1'b0;
      r_ovf_dec  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      // NOTE: the display register is reset so the board shows all-blank, not X.
      r_seg      <= {DIGITS{SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_bin      <= value;
            r_hex      <= hex_mode;
            r_blank_lz <= blank_lz;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_dec  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= hex_mode ? LOAD : SHIFT;
          end
        end
        SHIFT: begin
          r_bcd     <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin     <= r_bin << 1;
          r_ovf_dec <= r_ovf_dec | w_adj[BW-1];
          if (r_cnt == 5'(WIDTH - 1)) r_state <= LOAD;
          else                        r_cnt   <= r_cnt + 5'd1;
        end
        LOAD: begin
          r_seg      <= w_seg;
          r_overflow <= w_ovf;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign seg      = r_seg;

endmodule
